// File: rtl/mul_wb_pkg.sv
// Shared types and constants for the multiplier writeback stage.
// Imported by the product FIFO and the writeback top.
package mul_wb_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int WORD_SIZE  = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WR_LO,
    WR_HI
  } state_t;

endpackage

// File: rtl/prod_fifo.sv
// Two-entry product FIFO with head-of-queue read.
// Clear is asynchronous and active-low.
module prod_fifo
  import mul_wb_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wptr;
  logic         rptr;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/mul_hilo_wb.sv
// Writeback of signed double-width products into LO then HI
// over the shared internal bus, with zero/negative flags.
module mul_hilo_wb
  import mul_wb_pkg::*;
#(
  parameter int word_size = WORD_SIZE
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   prod_valid,
  input  logic [2*word_size-1:0] prod,
  output logic                   prod_ready,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic [word_size-1:0]   bus_out,
  output logic                   lo_in,
  output logic                   hi_in,
  output logic                   busy,
  output logic                   flag_z,
  output logic                   flag_n
);

  localparam int PW = 2 * word_size;

  state_t          state;
  state_t          nxt;
  logic            push;
  logic            pop;
  logic [PW-1:0]   head;
  logic [1:0]      count;

  assign prod_ready = clr & (count != 2'd2);
  assign push       = prod_valid & prod_ready;
  assign pop        = (state == WR_HI);

  prod_fifo #(.W(PW)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (prod),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      state <= IDLE;
    else
      state <= nxt;
  end

  // leaving WR_HI: count after this edge is count-1+push
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = (count != 2'd0) ? REQ : IDLE;
      REQ:   nxt = bus_gnt ? WR_LO : REQ;
      WR_LO: nxt = WR_HI;
      WR_HI: nxt = ((count > 2'd1) || push) ? REQ : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_out = '0;
    lo_in   = 1'b0;
    hi_in   = 1'b0;
    unique case (state)
      WR_LO: begin
        bus_out = head[word_size-1:0];
        lo_in   = 1'b1;
      end
      WR_HI: begin
        bus_out = head[PW-1:word_size];
        hi_in   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_req = (state != IDLE);
  assign busy    = (count != 2'd0) | (state != IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (pop) begin
      flag_z <= (head == '0);
      flag_n <= head[PW-1];
    end
  end

endmodule

// File: tb/tb_mul_hilo_wb.sv
// Directed bench for mul_hilo_wb: latency, grant stall,
// FIFO backpressure, mid-transfer clear and push/pop overlap.
module tb_mul_hilo_wb;

  logic        clk;
  logic        clr;
  logic        prod_valid;
  logic [63:0] prod;
  logic        prod_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] bus_out;
  logic        lo_in;
  logic        hi_in;
  logic        busy;
  logic        flag_z;
  logic        flag_n;

  int pass_cnt;
  int total_cnt;

  mul_hilo_wb #(.word_size(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_out    (bus_out),
    .lo_in      (lo_in),
    .hi_in      (hi_in),
    .busy       (busy),
    .flag_z     (flag_z),
    .flag_n     (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got hang, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr        = 1'b0;
    prod_valid = 1'b0;
    prod       = '0;
    bus_gnt    = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({prod_ready, bus_req, lo_in, hi_in, busy, flag_z, flag_n, bus_out}
        !== 39'd0)
      $display("FAIL reset_outs: got rdy=%b req=%b lo=%b hi=%b busy=%b z=%b n=%b bus=%h want all 0",
               prod_ready, bus_req, lo_in, hi_in, busy, flag_z, flag_n, bus_out);
    else pass_cnt++;
    clr = 1'b1;
    #1;
    total_cnt++;
    if (prod_ready !== 1'b1)
      $display("FAIL reset_release_ready: got %b want 1", prod_ready);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_single();
    bus_gnt    = 1'b1;
    prod       = 64'h00000003_FFFFFFFA;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    total_cnt++;
    if ({bus_req, busy} !== 2'b01)
      $display("FAIL single_e0: got req=%b busy=%b want req=0 busy=1", bus_req, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus_req, lo_in, hi_in} !== 3'b100)
      $display("FAIL single_e1_req: got req=%b lo=%b hi=%b want 1 0 0", bus_req, lo_in, hi_in);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({lo_in, hi_in, bus_out} !== {2'b10, 32'hFFFFFFFA})
      $display("FAIL single_lo: got lo=%b hi=%b bus=%h want 1 0 fffffffa", lo_in, hi_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({lo_in, hi_in, bus_out} !== {2'b01, 32'h00000003})
      $display("FAIL single_hi: got lo=%b hi=%b bus=%h want 0 1 00000003", lo_in, hi_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, bus_req, flag_z, flag_n, bus_out} !== 36'd0)
      $display("FAIL single_done: got busy=%b req=%b z=%b n=%b bus=%h want all 0",
               busy, bus_req, flag_z, flag_n, bus_out);
    else pass_cnt++;
  endtask

  task automatic test_delayed_gnt();
    int req_cycles;
    bus_gnt    = 1'b0;
    prod       = 64'hFFFFFFFF_FFFFFFF8;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_req && !lo_in && !hi_in)
        req_cycles++;
    end
    total_cnt++;
    if (req_cycles != 6)
      $display("FAIL delayed_req_hold: got %0d req cycles want 6", req_cycles);
    else pass_cnt++;
    bus_gnt = 1'b1;
    tick();
    total_cnt++;
    if ({lo_in, hi_in, bus_out} !== {2'b10, 32'hFFFFFFF8})
      $display("FAIL delayed_lo: got lo=%b hi=%b bus=%h want 1 0 fffffff8", lo_in, hi_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({lo_in, hi_in, bus_out} !== {2'b01, 32'hFFFFFFFF})
      $display("FAIL delayed_hi: got lo=%b hi=%b bus=%h want 0 1 ffffffff", lo_in, hi_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, flag_z, flag_n} !== 3'b001)
      $display("FAIL delayed_flags: got busy=%b z=%b n=%b want 0 0 1", busy, flag_z, flag_n);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    bus_gnt    = 1'b1;
    prod       = 64'h0;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({lo_in, hi_in, bus_out} !== {2'b10, 32'h0})
      $display("FAIL zero_lo: got lo=%b hi=%b bus=%h want 1 0 0", lo_in, hi_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({lo_in, hi_in, bus_out} !== {2'b01, 32'h0})
      $display("FAIL zero_hi: got lo=%b hi=%b bus=%h want 0 1 0", lo_in, hi_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, flag_z, flag_n} !== 3'b010)
      $display("FAIL zero_flags: got busy=%b z=%b n=%b want 0 1 0", busy, flag_z, flag_n);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_bus [8];
    logic [1:0]  exp_lh  [8];
    exp_bus = '{32'h22222222, 32'h11111111, 32'h0,
                32'h44444444, 32'h33333333, 32'h0,
                32'h00000005, 32'h80000000};
    exp_lh  = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
    bus_gnt    = 1'b0;
    prod       = 64'h11111111_22222222;
    prod_valid = 1'b1;
    tick();
    total_cnt++;
    if (prod_ready !== 1'b1)
      $display("FAIL b2b_ready_one: got %b want 1", prod_ready);
    else pass_cnt++;
    prod = 64'h33333333_44444444;
    tick();
    total_cnt++;
    if (prod_ready !== 1'b0)
      $display("FAIL b2b_full: got ready=%b want 0", prod_ready);
    else pass_cnt++;
    prod = 64'h80000000_00000005;
    tick();
    total_cnt++;
    if ({prod_ready, bus_req, lo_in} !== 3'b010)
      $display("FAIL b2b_stall: got rdy=%b req=%b lo=%b want 0 1 0", prod_ready, bus_req, lo_in);
    else pass_cnt++;
    bus_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total_cnt++;
      if ({bus_req, lo_in, hi_in, bus_out} !== {1'b1, exp_lh[i], exp_bus[i]})
        $display("FAIL b2b_cycle%0d: got req=%b lo=%b hi=%b bus=%h want 1 %b %h",
                 i, bus_req, lo_in, hi_in, bus_out, exp_lh[i], exp_bus[i]);
      else pass_cnt++;
      if (i == 1) begin
        total_cnt++;
        if (prod_ready !== 1'b0)
          $display("FAIL b2b_no_bypass: got ready=%b want 0", prod_ready);
        else pass_cnt++;
      end
      if (i == 2) begin
        total_cnt++;
        if (prod_ready !== 1'b1)
          $display("FAIL b2b_slot_freed: got ready=%b want 1", prod_ready);
        else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++;
        if (prod_ready !== 1'b0)
          $display("FAIL b2b_third_taken: got ready=%b want 0", prod_ready);
        else pass_cnt++;
        prod_valid = 1'b0;
      end
    end
    tick();
    total_cnt++;
    if ({busy, flag_z, flag_n} !== 3'b001)
      $display("FAIL b2b_done: got busy=%b z=%b n=%b want 0 0 1", busy, flag_z, flag_n);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int hi_seen;
    bus_gnt    = 1'b0;
    prod       = 64'hAAAAAAAA_BBBBBBBB;
    prod_valid = 1'b1;
    tick();
    prod = 64'hCCCCCCCC_DDDDDDDD;
    tick();
    prod_valid = 1'b0;
    bus_gnt    = 1'b1;
    tick();
    total_cnt++;
    if ({lo_in, bus_out} !== {1'b1, 32'hBBBBBBBB})
      $display("FAIL mid_lo_before: got lo=%b bus=%h want 1 bbbbbbbb", lo_in, bus_out);
    else pass_cnt++;
    #1;
    clr = 1'b0;
    #1;
    total_cnt++;
    if ({lo_in, hi_in, bus_req, busy, prod_ready, bus_out} !== 37'd0)
      $display("FAIL mid_clr_async: got lo=%b hi=%b req=%b busy=%b rdy=%b bus=%h want all 0",
               lo_in, hi_in, bus_req, busy, prod_ready, bus_out);
    else pass_cnt++;
    hi_seen = 0;
    tick();
    if (hi_in) hi_seen++;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (hi_in || busy) hi_seen++;
    end
    total_cnt++;
    if (hi_seen != 0)
      $display("FAIL mid_no_hi: got %0d hi/busy cycles want 0", hi_seen);
    else pass_cnt++;
    prod       = 64'h00000000_00000007;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({lo_in, bus_out} !== {1'b1, 32'h00000007})
      $display("FAIL mid_after_lo: got lo=%b bus=%h want 1 00000007", lo_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({hi_in, bus_out} !== {1'b1, 32'h0})
      $display("FAIL mid_after_hi: got hi=%b bus=%h want 1 0", hi_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, flag_z, flag_n} !== 3'b000)
      $display("FAIL mid_after_flags: got busy=%b z=%b n=%b want 0 0 0", busy, flag_z, flag_n);
    else pass_cnt++;
  endtask

  task automatic test_push_pop();
    bus_gnt    = 1'b1;
    prod       = 64'h0000000A_0000000B;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({lo_in, bus_out} !== {1'b1, 32'h0000000B})
      $display("FAIL pp_x_lo: got lo=%b bus=%h want 1 0000000b", lo_in, bus_out);
    else pass_cnt++;
    tick();
    prod       = 64'hFFFFFFFF_00000000;
    prod_valid = 1'b1;
    total_cnt++;
    if ({hi_in, bus_out, prod_ready} !== {1'b1, 32'h0000000A, 1'b1})
      $display("FAIL pp_x_hi: got hi=%b bus=%h rdy=%b want 1 0000000a 1", hi_in, bus_out, prod_ready);
    else pass_cnt++;
    tick();
    prod_valid = 1'b0;
    total_cnt++;
    if ({bus_req, busy, prod_ready, lo_in, hi_in, flag_z, flag_n} !== 7'b1110000)
      $display("FAIL pp_overlap: got req=%b busy=%b rdy=%b lo=%b hi=%b z=%b n=%b want 1 1 1 0 0 0 0",
               bus_req, busy, prod_ready, lo_in, hi_in, flag_z, flag_n);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({lo_in, bus_out} !== {1'b1, 32'h00000000})
      $display("FAIL pp_y_lo: got lo=%b bus=%h want 1 0", lo_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({hi_in, bus_out} !== {1'b1, 32'hFFFFFFFF})
      $display("FAIL pp_y_hi: got hi=%b bus=%h want 1 ffffffff", hi_in, bus_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, bus_req, flag_z, flag_n} !== 4'b0001)
      $display("FAIL pp_done: got busy=%b req=%b z=%b n=%b want 0 0 0 1 (no duplicate)",
               busy, bus_req, flag_z, flag_n);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_delayed_gnt();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_push_pop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
